// File: rtl/scan_blink_ctrl.sv
// scan_blink_ctrl: digit-slot scan counter plus per-field blink generator
// for the watch display. The scan side produces a slot index 0..5 with a
// matching one-cycle tick. The blink side blanks the field being edited
// for alternating BLINK_DIV-cycle half-periods, and restarts visible on
// every mode change or adjust press.
// SCAN_DIV and BLINK_DIV must both be at least 2.
module scan_blink_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic       adj,
  output logic [2:0] cnt,
  output logic [2:0] blink,
  output logic       slot_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_div;
  logic [BW-1:0] blink_div;
  logic          phase;
  logic [2:0]    state_q;

  logic [2:0]    state_n;
  logic [2:0]    field_sel;
  logic          restart;
  logic [BW-1:0] blink_div_nxt;
  logic          phase_nxt;

  // Reserved encoding 7 behaves exactly like time display; the field
  // select decodes which digit pair the current mode is editing.
  always_comb begin
    state_n   = (state == 3'd7) ? 3'd0 : state;
    field_sel = 3'b000;
    case (state_n)
      3'd1:       field_sel = 3'b001;
      3'd2, 3'd5: field_sel = 3'b010;
      3'd3, 3'd6: field_sel = 3'b100;
      default:    field_sel = 3'b000;
    endcase
  end

  // Next blink divider / phase. A mode change and an adjust press share
  // one restart term, so both together still give a single restart.
  // NOTE: every always_comb output gets a default before any branch;
  // a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    restart       = adj | (state_n != state_q);
    blink_div_nxt = blink_div + BW'(1);
    phase_nxt     = phase;
    if (restart) begin
      blink_div_nxt = '0;
      phase_nxt     = 1'b0;
    end else if (blink_div == BLINK_MAX) begin
      blink_div_nxt = '0;
      phase_nxt     = ~phase;
    end
  end

  // Scan divider, slot index and slot tick; independent of mode and adjust.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_div  <= '0;
      cnt       <= 3'd0;
      slot_tick <= 1'b0;
    end else if (scan_div == SCAN_MAX) begin
      scan_div  <= '0;
      slot_tick <= 1'b1;
      cnt       <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
    end else begin
      scan_div  <= scan_div + SW'(1);
      slot_tick <= 1'b0;
    end
  end

  // Blink divider, phase, registered mode and registered blank request.
  // The blank request is built from the post-edge phase so a restart shows
  // the new field visible on the very edge that restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_div <= '0;
      phase     <= 1'b0;
      state_q   <= 3'd0;
      blink     <= 3'b000;
    end else begin
      blink_div <= blink_div_nxt;
      phase     <= phase_nxt;
      state_q   <= state_n;
      blink     <= field_sel & {3{phase_nxt}};
    end
  end

endmodule

// File: tb/tb_scan_blink_ctrl.sv
// tb_scan_blink_ctrl: self-checking bench for scan_blink_ctrl with
// SCAN_DIV=4, BLINK_DIV=8. A cycle-count reference model (edges since
// reset, edge of last restart) predicts every output on every edge;
// a constant vector table and hand-written sequences pin the corner cases.
module tb_scan_blink_ctrl;

  localparam int SDIV = 4;
  localparam int BDIV = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] state;
  logic       adj;
  logic [2:0] cnt;
  logic [2:0] blink;
  logic       slot_tick;

  int passed = 0;
  int total  = 0;

  // reference model state
  int         m_edges;
  int         m_restart;
  logic [2:0] m_prev;

  typedef struct {
    logic [2:0] st;
    logic       adj;
    logic [2:0] cnt;
    logic       tick;
    logic [2:0] blink;
  } vec_t;

  vec_t vecs [12];

  scan_blink_ctrl #(.SCAN_DIV(SDIV), .BLINK_DIV(BDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .adj       (adj),
    .cnt       (cnt),
    .blink     (blink),
    .slot_tick (slot_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  function automatic logic [2:0] field_of(input logic [2:0] s);
    case (s)
      3'd1:       return 3'b001;
      3'd2, 3'd5: return 3'b010;
      3'd3, 3'd6: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] norm(input logic [2:0] s);
    return (s == 3'd7) ? 3'd0 : s;
  endfunction

  task automatic model_reset();
    m_edges   = 0;
    m_restart = 0;
    m_prev    = 3'd0;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge,
  // then compare all outputs shortly after it.
  task automatic step();
    logic [2:0] s;
    int         ph;
    logic [2:0] e_blink;
    @(posedge clk);
    s = norm(state);
    m_edges++;
    if (adj || s != m_prev) m_restart = m_edges;
    m_prev  = s;
    ph      = ((m_edges - m_restart) / BDIV) % 2;
    e_blink = (ph == 1) ? field_of(s) : 3'b000;
    #1;
    check("model_cnt",  32'(cnt),       32'((m_edges / SDIV) % 6));
    check("model_tick", 32'(slot_tick), 32'((m_edges % SDIV) == 0));
    check("model_blink", 32'(blink),    32'(e_blink));
  endtask

  task automatic wait_blink(input logic [2:0] target, input int budget);
    int k = 0;
    while (blink !== target && k < budget) begin
      step();
      k++;
    end
    if (blink !== target) check("wait_blink_timeout", 32'(blink), 32'(target));
  endtask

  initial begin
    // edges 1..12 with state=2 from reset; first edge restarts (0 -> 2)
    vecs[0]  = '{3'd2, 1'b0, 3'd0, 1'b0, 3'b000};
    vecs[1]  = '{3'd2, 1'b0, 3'd0, 1'b0, 3'b000};
    vecs[2]  = '{3'd2, 1'b0, 3'd0, 1'b0, 3'b000};
    vecs[3]  = '{3'd2, 1'b0, 3'd1, 1'b1, 3'b000};
    vecs[4]  = '{3'd2, 1'b0, 3'd1, 1'b0, 3'b000};
    vecs[5]  = '{3'd2, 1'b0, 3'd1, 1'b0, 3'b000};
    vecs[6]  = '{3'd2, 1'b0, 3'd1, 1'b0, 3'b000};
    vecs[7]  = '{3'd2, 1'b0, 3'd2, 1'b1, 3'b000};
    vecs[8]  = '{3'd2, 1'b0, 3'd2, 1'b0, 3'b010};
    vecs[9]  = '{3'd2, 1'b0, 3'd2, 1'b0, 3'b010};
    vecs[10] = '{3'd2, 1'b0, 3'd2, 1'b0, 3'b010};
    vecs[11] = '{3'd2, 1'b0, 3'd3, 1'b1, 3'b010};

    rst_n = 1'b0;
    state = 3'd2;
    adj   = 1'b0;
    model_reset();
    #3;
    check("reset_cnt",   32'(cnt),       32'd0);
    check("reset_blink", 32'(blink),     32'd0);
    check("reset_tick",  32'(slot_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: scan cadence and set-minutes blink from reset
    for (int i = 0; i < 12; i++) begin
      state = vecs[i].st;
      adj   = vecs[i].adj;
      step();
      check($sformatf("vec%0d_cnt", i),   32'(cnt),       32'(vecs[i].cnt));
      check($sformatf("vec%0d_tick", i),  32'(slot_tick), 32'(vecs[i].tick));
      check($sformatf("vec%0d_blink", i), 32'(blink),     32'(vecs[i].blink));
    end

    // async reset between edges while cnt=3, blink=010
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cnt",   32'(cnt),       32'd0);
    check("async_blink", 32'(blink),     32'd0);
    check("async_tick",  32'(slot_tick), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    state = 3'd0;
    model_reset();
    for (int i = 1; i <= SDIV; i++) begin
      step();
      check($sformatf("post_rst_tick%0d", i), 32'(slot_tick), 32'(i == SDIV));
    end

    // time display: 40 cycles, no blanking
    for (int i = 0; i < 40; i++) begin
      step();
      check("disp_blink", 32'(blink), 32'd0);
    end

    // set minutes via state 5
    state = 3'd5;
    wait_blink(3'b010, 40);

    // mode change 1 -> 3 while seconds blanked
    state = 3'd1;
    wait_blink(3'b001, 40);
    state = 3'd3;
    step();
    check("mode_chg_visible", 32'(blink), 32'd0);
    for (int i = 1; i < BDIV; i++) step();
    check("mode_chg_pre", 32'(blink), 32'd0);
    step();
    check("mode_chg_blank", 32'(blink), 32'b100);

    // adjust in alarm-hours: pulse, then hold 20 cycles
    state = 3'd6;
    wait_blink(3'b100, 40);
    adj = 1'b1;
    step();
    check("adj_pulse", 32'(blink), 32'd0);
    adj = 1'b0;
    step();
    adj = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("adj_held", 32'(blink), 32'd0);
    end
    adj = 1'b0;
    wait_blink(3'b100, 40);

    // reserved encoding
    state = 3'd7;
    for (int i = 0; i < 30; i++) begin
      step();
      check("reserved_blink", 32'(blink), 32'd0);
      check("reserved_cnt_range", 32'(cnt <= 3'd5), 32'd1);
    end

    // randomized modes and adjust presses against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) state = 3'($urandom_range(0, 7));
      adj = ($urandom_range(0, 15) == 0);
      step();
    end
    adj = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
